// File: rtl/fp_add_sequencer_pkg.sv
// Shared definitions for the 16-bit floating-point add/subtract sequencer.
// Format: {sign, exponent[EXP_W-1:0] unsigned, mantissa[MAN_W-1:0] with explicit leading one}.
package fp_add_sequencer_pkg;

  localparam int FP_EXP_W = 7;
  localparam int FP_MAN_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    DONE
  } state_t;

endpackage

// File: rtl/fp_add_sequencer_adder.sv
// Shared 8-bit mantissa adder/subtractor; subtraction assumes Pm >= Qm.
module MantissaAdder (
  input  logic [7:0] Pm,
  input  logic [7:0] Qm,
  input  logic       MAS,
  output logic [8:0] Sm
);

  assign Sm = MAS ? ({1'b0, Pm} + {1'b0, Qm}) : {1'b0, Pm - Qm};

endmodule

// File: rtl/fp_add_sequencer.sv
// Multi-cycle FP add/subtract controller: capture/swap, align, add, normalize, present result.
module fp_add_sequencer
  import fp_add_sequencer_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic                   op_sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   ovf,
  output logic                   unf,
  output logic                   busy
);

  localparam int FW    = EXP_W + MAN_W;
  localparam int CNT_W = $clog2(MAN_W);

  state_t state, state_nx;

  logic               sb, swap, a_zero, b_zero, far;
  logic [EXP_W-1:0]   el_c, es_c, d_c;
  logic [MAN_W-1:0]   ml_c, ms_c;

  logic               sign_r, eff_sub_r, mas;
  logic [EXP_W-1:0]   el_r;
  logic [MAN_W-1:0]   ml_r, ms_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [MAN_W:0]     sm_r, sum;

  // Swap on full {E,M} magnitude so the adder always sees Pm >= Qm.
  assign sb     = b[FW] ^ op_sub;
  assign swap   = b[FW-1:0] > a[FW-1:0];
  assign el_c   = swap ? b[FW-1:MAN_W] : a[FW-1:MAN_W];
  assign es_c   = swap ? a[FW-1:MAN_W] : b[FW-1:MAN_W];
  assign ml_c   = swap ? b[MAN_W-1:0]  : a[MAN_W-1:0];
  assign ms_c   = swap ? a[MAN_W-1:0]  : b[MAN_W-1:0];
  assign d_c    = el_c - es_c;
  assign far    = d_c >= EXP_W'(MAN_W);
  assign a_zero = a[MAN_W-1:0] == '0;
  assign b_zero = b[MAN_W-1:0] == '0;
  assign mas    = ~eff_sub_r;

  MantissaAdder u_adder (
    .Pm  (ml_r),
    .Qm  (ms_r),
    .MAS (mas),
    .Sm  (sum)
  );

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          if (a_zero || b_zero)        state_nx = DONE;
          else if (far || d_c == '0)   state_nx = ADD;
          else                         state_nx = ALIGN;
        end
      end
      ALIGN: if (cnt_r == CNT_W'(1)) state_nx = ADD;
      ADD: begin
        if (sum == '0 || (!sum[MAN_W] && sum[MAN_W-1])) state_nx = DONE;
        else                                             state_nx = NORM;
      end
      NORM: begin
        if (sm_r[MAN_W] || el_r == '0 || sm_r[MAN_W-2]) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      result    <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      sign_r    <= 1'b0;
      eff_sub_r <= 1'b0;
      el_r      <= '0;
      ml_r      <= '0;
      ms_r      <= '0;
      cnt_r     <= '0;
      sm_r      <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_r    <= swap ? sb : a[FW];
            eff_sub_r <= a[FW] ^ sb;
            el_r      <= el_c;
            ml_r      <= ml_c;
            ms_r      <= far ? '0 : ms_c;
            cnt_r     <= d_c[CNT_W-1:0];
            if (a_zero)      result <= {sb, b[FW-1:0]};
            else if (b_zero) result <= a;
          end
        end
        ALIGN: begin
          ms_r  <= ms_r >> 1;
          cnt_r <= cnt_r - 1'b1;
        end
        ADD: begin
          sm_r <= sum;
          if (sum == '0)                            result <= '0;
          else if (!sum[MAN_W] && sum[MAN_W-1])     result <= {sign_r, el_r, sum[MAN_W-1:0]};
        end
        NORM: begin
          if (sm_r[MAN_W]) begin
            if (el_r == '1) begin
              result <= {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
              ovf    <= 1'b1;
            end else begin
              result <= {sign_r, el_r + 1'b1, sm_r[MAN_W:1]};
            end
          end else if (el_r == '0) begin
            result <= '0;
            unf    <= 1'b1;
          end else begin
            // Result is written in the same cycle as the final shift so DONE follows directly.
            sm_r <= sm_r << 1;
            el_r <= el_r - 1'b1;
            if (sm_r[MAN_W-2]) result <= {sign_r, el_r - 1'b1, sm_r[MAN_W-2:0], 1'b0};
          end
        end
        DONE: begin
          if (out_ready) begin
            ovf <= 1'b0;
            unf <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
